// File: rtl/noc_input_port_wh.sv
// Wormhole input port: DEPTH-entry flit FIFO with XY routing computed from each
// packet's head flit and held for the body flits until the EOP flit departs.
module noc_input_port_wh #(
  parameter int X_W       = 1,
  parameter int Y_W       = 1,
  parameter int TYPE_W    = 2,
  parameter int PAYLOAD_W = 8,
  parameter int DEPTH     = 4,
  parameter int LOCAL_X   = 0,
  parameter int LOCAL_Y   = 0,
  parameter int CNT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [Y_W+X_W+TYPE_W+PAYLOAD_W:0]   in_flit,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic                                ack,
  output logic [Y_W+X_W+TYPE_W+PAYLOAD_W:0]   out_flit,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [4:0]                          out_route,
  output logic [TYPE_W-1:0]                   out_type,
  output logic                                out_head,
  output logic [CNT_W-1:0]                    flit_count,
  output logic [CNT_W-1:0]                    pkt_count
);

  localparam int FLIT_W  = Y_W + X_W + TYPE_W + PAYLOAD_W + 1;
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TYPE_LO = PAYLOAD_W + 1;
  localparam int X_LO    = TYPE_LO + TYPE_W;
  localparam int Y_LO    = X_LO + X_W;

  localparam logic [AW:0]      FULL_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]      ONE_C   = (AW+1)'(1);
  localparam logic [AW-1:0]    PONE_C  = AW'(1);
  localparam logic [CNT_W-1:0] CONE_C  = CNT_W'(1);
  localparam logic [X_W-1:0]   LX_C    = X_W'(LOCAL_X);
  localparam logic [Y_W-1:0]   LY_C    = Y_W'(LOCAL_Y);

  localparam logic [4:0] R_LOCAL = 5'b00001;
  localparam logic [4:0] R_NORTH = 5'b00010;
  localparam logic [4:0] R_EAST  = 5'b00100;
  localparam logic [4:0] R_SOUTH = 5'b01000;
  localparam logic [4:0] R_WEST  = 5'b10000;

  typedef enum logic {HEAD, BODY} state_t;

  // Dimension-ordered routing: X is resolved completely before Y.
  function automatic logic [4:0] xy_route(input logic [X_W-1:0] dx,
                                          input logic [Y_W-1:0] dy);
    logic [4:0] r;
    if (dx > LX_C)      r = R_EAST;
    else if (dx < LX_C) r = R_WEST;
    else if (dy > LY_C) r = R_NORTH;
    else if (dy < LY_C) r = R_SOUTH;
    else                r = R_LOCAL;
    return r;
  endfunction

  logic [FLIT_W-1:0] mem_p1 [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              push, pop;
  logic              ack_p1;
  logic [FLIT_W-1:0] head_flit;
  logic              head_eop;

  state_t            state, state_nxt;
  logic              lock_en;
  logic [4:0]        route_lock;
  logic [TYPE_W-1:0] type_lock;

  assign in_ready  = (count != FULL_C);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head_flit = mem_p1[rd_ptr];
  assign head_eop  = head_flit[0];
  assign ack       = ack_p1;

  // Storage stage: flit data is written without reset; emptiness gates the outputs.
  always_ff @(posedge clk) begin
    if (push) mem_p1[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ack_p1     <= 1'b0;
      state      <= HEAD;
      flit_count <= '0;
      pkt_count  <= '0;
    end else begin
      ack_p1 <= push;
      state  <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PONE_C;
      if (pop)  rd_ptr <= rd_ptr + PONE_C;
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
      if (pop)             flit_count <= flit_count + CONE_C;
      if (pop && head_eop) pkt_count  <= pkt_count + CONE_C;
    end
  end

  // Locked route is only consulted in BODY, which reset leaves; no reset needed.
  always_ff @(posedge clk) begin
    if (lock_en) begin
      route_lock <= xy_route(head_flit[X_LO +: X_W], head_flit[Y_LO +: Y_W]);
      type_lock  <= head_flit[TYPE_LO +: TYPE_W];
    end
  end

  always_comb begin
    state_nxt = state;
    lock_en   = 1'b0;
    out_flit  = '0;
    out_route = '0;
    out_type  = '0;
    out_head  = 1'b0;
    case (state)
      HEAD: begin
        if (pop && !head_eop) begin
          state_nxt = BODY;
          lock_en   = 1'b1;
        end
      end
      BODY: begin
        if (pop && head_eop) state_nxt = HEAD;
      end
      default: state_nxt = HEAD;
    endcase
    if (out_valid) begin
      out_flit = head_flit;
      if (state == HEAD) begin
        out_head  = 1'b1;
        out_route = xy_route(head_flit[X_LO +: X_W], head_flit[Y_LO +: Y_W]);
        out_type  = head_flit[TYPE_LO +: TYPE_W];
      end else begin
        out_route = route_lock;
        out_type  = type_lock;
      end
    end
  end

endmodule

// File: tb/tb_noc_input_port_wh.sv
// Bench for noc_input_port_wh: queue-based packet model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_noc_input_port_wh;

  localparam int X_W = 2, Y_W = 2, TYPE_W = 2, PAYLOAD_W = 8;
  localparam int DEPTH = 4, LX = 1, LY = 1, CNT_W = 4;
  localparam int FW = Y_W + X_W + TYPE_W + PAYLOAD_W + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, ack, out_valid, out_head;
  logic [FW-1:0] out_flit;
  logic [4:0]    out_route;
  logic [1:0]    out_type;
  logic [3:0]    flit_count, pkt_count;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] q[$];
  bit            in_body;
  logic [4:0]    lk_route;
  logic [1:0]    lk_type;
  logic [3:0]    m_flit, m_pkt;
  logic          m_ack;

  noc_input_port_wh #(
    .X_W(X_W), .Y_W(Y_W), .TYPE_W(TYPE_W), .PAYLOAD_W(PAYLOAD_W),
    .DEPTH(DEPTH), .LOCAL_X(LX), .LOCAL_Y(LY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_ready(in_ready), .ack(ack), .out_flit(out_flit), .out_valid(out_valid),
    .out_ready(out_ready), .out_route(out_route), .out_type(out_type),
    .out_head(out_head), .flit_count(flit_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  function automatic logic [FW-1:0] mk(input logic [1:0] y, input logic [1:0] x,
                                       input logic [1:0] t, input logic [7:0] p,
                                       input logic e);
    return {y, x, t, p, e};
  endfunction

  function automatic logic [4:0] route_of(input logic [1:0] x, input logic [1:0] y);
    if (int'(x) > LX) return 5'b00100;
    if (int'(x) < LX) return 5'b10000;
    if (int'(y) > LY) return 5'b00010;
    if (int'(y) < LY) return 5'b01000;
    return 5'b00001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    in_body = 0;
    lk_route = '0;
    lk_type = '0;
    m_flit = '0;
    m_pkt = '0;
    m_ack = 1'b0;
  endtask

  task automatic check_all();
    logic [FW-1:0] h;
    logic [4:0] er;
    logic [1:0] et;
    logic eh;
    if (q.size() == 0) begin
      h = '0; er = '0; et = '0; eh = 1'b0;
    end else begin
      h = q[0];
      if (!in_body) begin
        er = route_of(h[12:11], h[14:13]);
        et = h[10:9];
        eh = 1'b1;
      end else begin
        er = lk_route;
        et = lk_type;
        eh = 1'b0;
      end
    end
    chk("in_ready", in_ready, 32'(q.size() != DEPTH));
    chk("out_valid", out_valid, 32'(q.size() != 0));
    chk("out_flit", out_flit, h);
    chk("out_route", out_route, er);
    chk("out_type", out_type, et);
    chk("out_head", out_head, eh);
    chk("ack", ack, m_ack);
    chk("flit_count", flit_count, m_flit);
    chk("pkt_count", pkt_count, m_pkt);
  endtask

  // One clock: compare at the falling edge, drive, then advance the model past the rising edge.
  task automatic step(input logic v, input logic [FW-1:0] f, input logic r);
    bit push, pop;
    logic [FW-1:0] g;
    check_all();
    in_valid = v;
    in_flit = f;
    out_ready = r;
    push = v && (q.size() != DEPTH);
    pop = r && (q.size() != 0);
    @(posedge clk);
    if (pop) begin
      g = q.pop_front();
      m_flit++;
      if (g[0]) m_pkt++;
      if (!in_body && !g[0]) begin
        in_body = 1;
        lk_route = route_of(g[12:11], g[14:13]);
        lk_type = g[10:9];
      end else if (in_body && g[0]) begin
        in_body = 0;
      end
    end
    if (push) q.push_back(f);
    m_ack = push;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_route", out_route, 0);
    chk("rst_out_head", out_head, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_counts", {flit_count, pkt_count}, 0);
    chk("rst_ack", ack, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0] rdx [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
  logic [1:0] rdy [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
  logic [4:0] rexp[4] = '{5'b10000, 5'b00010, 5'b01000, 5'b00001};

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // single-flit packet
    step(1'b1, mk(2'd1, 2'd1, 2'b01, 8'hA5, 1'b1), 1'b1);
    chk("sf_valid", out_valid, 1);
    chk("sf_route", out_route, 5'b00001);
    chk("sf_head", out_head, 1);
    chk("sf_type", out_type, 2'b01);
    chk("sf_ack", ack, 1);
    step(1'b0, '0, 1'b1);
    chk("sf_pkt", pkt_count, 1);
    chk("sf_flit", flit_count, 1);
    chk("sf_ack_low", ack, 0);

    // fill to full, then drain
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'(i + 1), 1'b1), 1'b0);
    chk("full_ready", in_ready, 0);
    step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'd5, 1'b1), 1'b0);
    chk("full_held", in_ready, 0);
    step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'd5, 1'b1), 1'b1);
    chk("full_reready", in_ready, 1);
    chk("full_order", out_flit, mk(2'd1, 2'd1, 2'b00, 8'd2, 1'b1));
    step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'd5, 1'b1), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    chk("full_drained", flit_count, 5);

    // 3-flit packet routed EAST throughout
    do_reset();
    step(1'b1, mk(2'd1, 2'd2, 2'b10, 8'h11, 1'b0), 1'b0);
    step(1'b1, mk(2'd0, 2'd0, 2'b11, 8'h22, 1'b0), 1'b0);
    step(1'b1, mk(2'd0, 2'd0, 2'b00, 8'h33, 1'b1), 1'b0);
    chk("pk_route0", out_route, 5'b00100);
    chk("pk_head0", out_head, 1);
    step(1'b0, '0, 1'b1);
    chk("pk_route1", out_route, 5'b00100);
    chk("pk_head1", out_head, 0);
    chk("pk_type1", out_type, 2'b10);
    step(1'b0, '0, 1'b1);
    chk("pk_route2", out_route, 5'b00100);
    chk("pk_head2", out_head, 0);
    step(1'b0, '0, 1'b1);
    chk("pk_empty_route", out_route, 0);
    chk("pk_pkts", pkt_count, 1);
    step(1'b1, mk(2'd1, 2'd1, 2'b01, 8'h44, 1'b1), 1'b0);
    chk("pk_back_head", out_head, 1);
    chk("pk_back_route", out_route, 5'b00001);
    step(1'b0, '0, 1'b1);

    // route directions
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(rdy[i], rdx[i], 2'b01, 8'(i), 1'b1), 1'b0);
      chk("route_dir", out_route, rexp[i]);
      step(1'b0, '0, 1'b1);
    end

    // count held at 2 under simultaneous push and pop
    do_reset();
    step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'hC0, 1'b1), 1'b0);
    step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'hC1, 1'b1), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 15'($urandom), 1'b1);
    chk("pp_ready", in_ready, 1);
    chk("pp_count", flit_count, 6);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("pp_empty", out_valid, 0);

    // reset while in BODY with three flits buffered
    do_reset();
    step(1'b1, mk(2'd1, 2'd2, 2'b10, 8'h01, 1'b0), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, mk(2'd0, 2'd0, 2'b00, 8'(i), 1'b0), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("rb_body", out_head, 0);
    do_reset();
    step(1'b1, mk(2'd1, 2'd0, 2'b11, 8'h55, 1'b1), 1'b0);
    chk("rb_head", out_head, 1);
    chk("rb_route", out_route, 5'b10000);
    step(1'b0, '0, 1'b1);

    // counter wrap
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, mk(2'd1, 2'd1, 2'b00, 8'(i), 1'b1), 1'b1);
    step(1'b0, '0, 1'b1);
    chk("wrap_pkt", pkt_count, 0);
    chk("wrap_flit", flit_count, 0);

    // randomized traffic with varying back-pressure
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      int bias;
      logic [FW-1:0] f;
      bias = (i / 100) % 4;
      f = 15'($urandom);
      f[0] = ($urandom_range(0, 2) == 0);
      if (i == 800) do_reset();
      step($urandom_range(0, 3) != 0, f, $urandom_range(0, 3) < bias + 1);
    end
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noc_input_port_wh.md
# noc_input_port_wh

Parametrised wormhole input port for the 2-D mesh NoC router. Accepts flits from an upstream link with a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and computes an XY route from the head flit of each packet. The route stays locked for all body flits until the EOP flit leaves. It feeds the router's switch allocator/crossbar: one instance per router input port (LOCAL, N, E, S, W).

## Interface
- X_W, 1: width of destination X coordinate
- Y_W, 1: width of destination Y coordinate
- TYPE_W, 2: packet type field width
- PAYLOAD_W, 8: payload width
- DEPTH, 4: FIFO entries; power of two, ≥2
- LOCAL_X, 0: this router's X coordinate
- LOCAL_Y, 0: this router's Y coordinate
- CNT_W, 16: statistics counter width
- Derived: FLIT_W = Y_W+X_W+TYPE_W+PAYLOAD_W+1. Flit layout MSB→LSB: {dst_y, dst_x, type, payload, eop}.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_flit  in  FLIT_W  incoming flit
- in_valid  in  1  upstream flit valid
- in_ready  out  1  port can accept a flit
- ack  out  1  one-cycle pulse per accepted flit (legacy upstream credit)
- out_flit  out  FLIT_W  flit at FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream grant; a flit transfers when out_valid && out_ready
- out_route  out  5  one-hot output port: bit0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST
- out_type  out  TYPE_W  type of current packet (from its head flit)
- out_head  out  1  out_flit is a head flit
- flit_count  out  CNT_W  flits dequeued, wraps
- pkt_count  out  CNT_W  EOP flits dequeued, wraps

## Operation
- FIFO: circular buffer with wr_ptr and rd_ptr (log2(DEPTH) bits, wrap naturally) and count (log2(DEPTH)+1 bits).
  - in_ready = (count != DEPTH). There is no write-through when full.
  - Push when in_valid && in_ready.
  - Pop on output transfer.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
- ack is registered: it is 1 in the cycle after each push, else 0.
- FSM, two states:
  - HEAD (reset state): out_head=1. out_route is computed combinationally from the head flit's dst fields. out_type = head flit type.
    - Transfer with eop=1: stay in HEAD (single-flit packet).
    - Transfer with eop=0: latch route and type, go to BODY.
  - BODY: out_head=0. out_route and out_type come from the latched values; dst/type bits of body flits are ignored.
    - Transfer with eop=1: go to HEAD.
- XY route, X resolved first, unsigned compare:
  - dst_x>LOCAL_X → EAST
  - dst_x<LOCAL_X → WEST
  - else dst_y>LOCAL_Y → NORTH
  - dst_y<LOCAL_Y → SOUTH
  - else LOCAL
- When out_valid=0: out_route=0, out_head=0, out_type=0, out_flit=0.
- Counters increment on each transfer. pkt_count increments only if the transferred flit has eop=1. Both wrap modulo 2^CNT_W.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, FSM=HEAD, both counters=0, ack=0.
  - Resulting outputs: in_ready=1, out_valid=0, out_route=0, out_head=0, out_type=0, out_flit=0.
- Reset mid-packet discards buffered flits and the locked route; the next accepted flit is treated as a head.
- Latency: a flit pushed at edge N appears on out_flit/out_valid after edge N (combinational FIFO head read, registered storage). Minimum in→out latency is 1 cycle.
- Throughput: 1 flit/cycle sustained when out_ready=1.
- out_* are stable while out_valid=1 && out_ready=0.
- in_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after a pop from full.

## Test plan
- Single-flit packet (defaults), in_flit={0,0,2'b01,8'hA5,1}, out_ready=1 → next cycle:
  - out_valid=1, out_route=5'b00001, out_head=1, out_type=01.
  - Then pkt_count=1, flit_count=1, ack pulses once.
- Fill with out_ready=0, push 5 flits back-to-back → after the 4th, in_ready=0 and the 5th is held. Raise out_ready → flits emerge in order, 1/cycle, and in_ready returns 1 one cycle after the first pop.
- 3-flit packet, head dst_x=1, body flits with dst_x=0, dst_y=0 → out_route=5'b00100 (EAST) for all three flits. out_head=1,0,0. FSM returns to HEAD after eop.
- LOCAL_X=1, LOCAL_Y=1, X_W=Y_W=2: heads to (0,1),(1,2),(1,0),(1,1) → WEST, NORTH, SOUTH, LOCAL.
- Count=2, simultaneous push and pop for 6 cycles → count stays 2, output sequence matches input order, no loss or duplication.
- Assert rst while in BODY with 3 flits buffered → immediately out_valid=0, in_ready=1, counters 0. Next flit is routed as a head. With CNT_W=4, 16 packets → pkt_count wraps to 0.
